// File: rtl/csa_accum.sv
// Carry-save packet accumulator: one full-add per beat, then a
// segmented ripple resolve of the saved sum/carry pair.
module csa_accum #(
  parameter int WIDTH = 64,
  parameter int SEG   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
);

  localparam int NSEG = WIDTH / SEG;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {
    ACC,
    RESOLVE,
    DONE
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] c_q;
  logic             ovf_q;
  logic             first_q;
  logic [KW-1:0]    k_q;
  logic             rc_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             rdy_q;
  logic             vld_q;

  logic [WIDTH-1:0] s_d;
  logic [WIDTH-1:0] maj;
  logic [WIDTH-1:0] c_d;
  logic [SEG:0]     seg_sum;
  logic             last_k;

  always_comb begin
    s_d = s_q ^ c_q ^ in_data;
    maj = (s_q & c_q) | (s_q & in_data) | (c_q & in_data);
    c_d = {maj[WIDTH-2:0], first_q & cin};
  end

  // One SEG-wide add per edge keeps the carry chain short.
  always_comb begin
    seg_sum = {1'b0, s_q[k_q*SEG +: SEG]}
            + {1'b0, c_q[k_q*SEG +: SEG]}
            + {{SEG{1'b0}}, rc_q};
    last_k  = (k_q == KW'(NSEG - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ACC;
      s_q     <= '0;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      first_q <= 1'b1;
      k_q     <= '0;
      rc_q    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ACC: begin
          if (in_valid) begin
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_q | maj[WIDTH-1];
            first_q <= 1'b0;
            if (in_last) begin
              state_q <= RESOLVE;
              rdy_q   <= 1'b0;
              k_q     <= '0;
              rc_q    <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          sum_q[k_q*SEG +: SEG] <= seg_sum[SEG-1:0];
          rc_q <= seg_sum[SEG];
          k_q  <= k_q + 1'b1;
          if (last_k) begin
            cout_q  <= ovf_q | seg_sum[SEG];
            state_q <= DONE;
            vld_q   <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            s_q     <= '0;
            c_q     <= '0;
            ovf_q   <= 1'b0;
            first_q <= 1'b1;
            state_q <= ACC;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ACC;
          rdy_q   <= 1'b1;
          vld_q   <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_sum   = sum_q;
  assign out_cout  = cout_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed + random scoreboard bench for csa_accum at
// WIDTH=64/SEG=16 and WIDTH=8/SEG=4.
module tb_csa_accum;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_last, cin;
  logic [63:0] in_data;
  logic        out_valid, out_ready, out_cout;
  logic [63:0] out_sum;

  logic        b_in_valid, b_in_ready, b_in_last, b_cin;
  logic [7:0]  b_in_data;
  logic        b_out_valid, b_out_ready, b_out_cout;
  logic [7:0]  b_out_sum;

  csa_accum #(.WIDTH(64), .SEG(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout)
  );

  csa_accum #(.WIDTH(8), .SEG(4)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_last(b_in_last), .cin(b_cin),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_cout(b_out_cout)
  );

  int total = 0;
  int bad   = 0;

  logic [64:0] sbq[$];
  logic [71:0] tot;
  bit          mfirst;

  logic [8:0]  bq[$];
  logic [15:0] btot;
  bit          bfirst;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [63:0] d, input bit l, input bit c);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    cin      = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    @(posedge clk);
    if (mfirst) tot = 72'(c);
    tot = tot + 72'(d);
    mfirst = 1'b0;
    if (l) begin
      sbq.push_back({|tot[71:64], tot[63:0]});
      mfirst = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string tag);
    logic [64:0] e;
    int n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 0, 1);
      return;
    end
    e = sbq.pop_front();
    chk({tag, "_sum"}, out_sum, e[63:0]);
    chk({tag, "_cout"}, out_cout, e[64]);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic bbeat(input logic [7:0] d, input bit l, input bit c);
    int n = 0;
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_in_last  = l;
    b_cin      = c;
    while (!b_in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!b_in_ready) chk("b_in_ready_timeout", 0, 1);
    @(posedge clk);
    if (bfirst) btot = 16'(c);
    btot = btot + 16'(d);
    bfirst = 1'b0;
    if (l) begin
      bq.push_back({|btot[15:8], btot[7:0]});
      bfirst = 1'b1;
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  initial begin
    logic [64:0] snap;
    logic [8:0]  be;
    int          n;
    bit          seen;
    int          len;

    in_valid = 0; in_last = 0; cin = 0; in_data = '0; out_ready = 0;
    b_in_valid = 0; b_in_last = 0; b_cin = 0; b_in_data = '0;
    b_out_ready = 0;
    mfirst = 1'b1; tot = '0;
    bfirst = 1'b1; btot = '0;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    rst = 1'b1;
    @(negedge clk);

    // all-ones plus carry-in wraps to zero with carry out
    beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat64", n, 4);
    chk("ones_sum_const", out_sum, 0);
    chk("ones_cout_const", out_cout, 1);
    take("ones");
    chk("ones_in_ready_after", in_ready, 1);

    beat(64'h1, 1'b0, 1'b0);
    beat(64'h2, 1'b0, 1'b1);
    beat(64'h3, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("three_in_ready_low", in_ready, 0);
      @(negedge clk);
    end
    chk("three_sum_const", out_sum, 64'h6);
    take("three");

    beat(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    beat(64'h8000_0000_0000_0000, 1'b0, 1'b0);
    beat(64'h1, 1'b1, 1'b0);
    take("csovf");

    // backpressure: hold the result for ten cycles
    beat(64'hDEAD_BEEF_0123_4567, 1'b0, 1'b1);
    beat(64'hFEDC_BA98_7654_3210, 1'b1, 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    snap = {out_cout, out_sum};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_stable", {out_valid, out_cout, out_sum}, {1'b1, snap});
      chk("bp_in_ready", in_ready, 0);
    end
    take("bp");
    chk("bp_out_valid_after", out_valid, 0);
    chk("bp_in_ready_after", in_ready, 1);
    beat(64'h10, 1'b1, 1'b0);
    take("bp_next");

    // reset while resolving segment k=2
    beat(64'hAAAA_5555_AAAA_5555, 1'b0, 1'b0);
    beat(64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_sum", out_sum, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    sbq.delete();
    mfirst = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_pulse", seen, 0);
    beat(64'h5, 1'b0, 1'b0);
    beat(64'h7, 1'b1, 1'b0);
    chk("post_rst_sb", sbq[0], 65'hC);
    take("post_rst");

    for (int p = 0; p < 6; p++) begin
      len = $urandom_range(1, 5);
      for (int j = 0; j < len; j++) begin
        beat({$urandom, $urandom}, (j == len - 1), 1'($urandom));
      end
      take("rand");
    end

    bbeat(8'hF0, 1'b0, 1'b1);
    bbeat(8'h0F, 1'b0, 1'b0);
    bbeat(8'h01, 1'b1, 1'b0);
    n = 0;
    while (!b_out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("lat8", n, 2);
    if (bq.size() == 0) begin
      chk("w8_sb_empty", 0, 1);
    end else begin
      be = bq.pop_front();
      chk("w8_sum", b_out_sum, be[7:0]);
      chk("w8_cout", b_out_cout, be[8]);
    end
    chk("w8_sum_const", b_out_sum, 8'h01);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    chk("w8_in_ready_after", b_in_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
